router_pkt_tx: RTL
==================

Name: router_pkt_tx

Overview:
- Packet source for the 1x3 router input port; generates the byte stream the router's input FSM consumes.
- Accepts a command (destination address, payload length) and the payload bytes, and buffers the whole payload internally.
- Transmits header, payload and parity under router busy flow control, then watches the router error flag and reports status.
- Used as the on-chip traffic source and as the bench-side driver model.

Parameters:
- ERR_WAIT, 3: cycles spent in CHK sampling err after the parity byte is accepted (>=1).
- DEPTH, 63: payload buffer depth in bytes; must be >= 63, the maximum 6-bit length.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  2  destination FIFO: 0, 1 or 2.
- cmd_len  in  6  payload length, 1..63.
- pl_valid  in  1  payload byte valid.
- pl_ready  out  1  payload byte accepted when pl_valid && pl_ready.
- pl_data  in  8  payload byte.
- busy  in  1  router busy; a byte is transferred on a rising edge where busy==0.
- err  in  1  router parity error flag.
- data_out  out  8  byte to router data input.
- pkt_valid  out  1  high for header and payload bytes, low for the parity byte.
- done  out  1  one-cycle pulse when a command completes.
- status_err  out  1  valid while done=1: packet rejected or router error seen.
- tx_active  out  1  high in states HDR/PLD/PAR/CHK.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; data_out=0, pkt_valid=0, done=0, status_err=0, tx_active=0, pl_ready=0; cmd_ready=1 once rstn is released.
  - Counters and parity register are cleared; buffer contents are don't-care.
  - Reset mid-packet aborts immediately; pkt_valid drops asynchronously. Router recovery is the system's responsibility.
- Output timing: data_out, pkt_valid and tx_active are decoded from state and registers only. There is no combinational path from busy.
- Header byte: hdr = {cmd_len, cmd_addr}.
- Parity: par = hdr XOR all payload bytes, accumulated as bytes are accepted.
- State machine:
  - IDLE: cmd_ready=1.
    - On command handshake with cmd_len==0 or cmd_addr==3: reject. Next cycle done=1, status_err=1; stay in IDLE; no bytes are driven.
    - Otherwise: capture hdr, par<=hdr, wcnt<=0, go to FILL.
  - FILL: pl_ready=1, cmd_ready=0.
    - Each payload handshake writes buf[wcnt], does par^=pl_data and wcnt++.
    - The handshake with wcnt==len-1 moves to HDR.
    - pl_valid low just holds in FILL; there is no timeout.
  - HDR: data_out=hdr, pkt_valid=1.
    - busy==0 at the edge: go to PLD with idx=0.
    - busy==1: hold; data_out and pkt_valid stay stable.
  - PLD: data_out=buf[idx], pkt_valid=1.
    - busy==0 at the edge: if idx==len-1 go to PAR, else idx++.
    - busy==1: hold.
  - PAR: data_out=par, pkt_valid=0.
    - busy==0 at the edge: go to CHK with ccnt=0 and err_sticky=0.
  - CHK: data_out=0, pkt_valid=0.
    - Each cycle: err_sticky|=err, ccnt++.
    - When ccnt==ERR_WAIT-1: go to IDLE; done=1 for one cycle; status_err=err_sticky|err on that same edge.
- Stall rule: stalls are unbounded; busy is held as long as the router requires.
- Command rule: cmd_valid outside IDLE is ignored (cmd_ready=0).
- Throughput: with busy=0 throughout, a packet takes len+2 cycles on the wire (HDR, len PLD, PAR), plus ERR_WAIT cycles in CHK.
- status_err returns to 0 when done deasserts.

Optional Feature:
- Macro ROUTER_TX_PAR_CORRUPT_EN.
- When defined:
  - Adds input port corrupt (1 bit), sampled at command handshake.
  - If set, the transmitted parity byte is ~par, so the router must raise err and status_err must be 1.
- When undefined: the port is absent and parity is always correct.

Test Plan:
1. addr=1, len=4, payload 0x11,0x22,0x33,0x44, busy=0 -> data_out 0x11,0x11,0x22,0x33,0x44 with pkt_valid=1; then 0x55 with pkt_valid=0; done 3 cycles later with status_err=0.
2. Same packet, busy=1 for 5 cycles while idx=2 -> data_out holds 0x33, pkt_valid stays 1; 0x44 appears the cycle after busy falls.
3. cmd_len=0, then cmd_addr=3 len=5 -> pkt_valid never rises; done with status_err=1 the cycle after each handshake; pl_ready stays 0.
4. addr=0, len=2, err pulsed for 1 cycle on the second CHK cycle -> done with status_err=1.
5. addr=2, len=63, payload 0..62, pl_valid toggling -> header 0xFE, 63 payload bytes in order, correct parity, no lost or duplicated byte.
6. rstn low while in PLD -> pkt_valid=0 and tx_active=0 immediately; after release cmd_ready=1 and a new len=1 packet transmits correctly.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port: buffers a payload, then sends header/payload/parity under busy.
// Optional: define ROUTER_TX_PAR_CORRUPT_EN to add the 'corrupt' input, which inverts the transmitted parity byte.
module router_pkt_tx #(
  parameter int ERR_WAIT = 3,
  parameter int DEPTH    = 63
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  input  logic       err,
`ifdef ROUTER_TX_PAR_CORRUPT_EN
  input  logic       corrupt,
`endif
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       done,
  output logic       status_err,
  output logic       tx_active
);

  localparam int CW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_HDR  = 3'd2,
    S_PLD  = 3'd3,
    S_PAR  = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  function automatic logic [7:0] par_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [7:0]      par_q, par_d;
  logic [5:0]      wcnt_q, wcnt_d;
  logic [5:0]      idx_q, idx_d;
  logic [CW-1:0]   ccnt_q, ccnt_d;
  logic            err_sticky_q, err_sticky_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            pl_ready_q, pl_ready_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            done_q, done_d;
  logic            status_err_q, status_err_d;
  logic            tx_active_q, tx_active_d;
`ifdef ROUTER_TX_PAR_CORRUPT_EN
  logic            corrupt_q, corrupt_d;
`endif
  logic [7:0]      pbuf_q [DEPTH];
  logic            buf_we_s;
  logic            cmd_hs_s;
  logic            pl_hs_s;
  logic [5:0]      len_s;
  logic [7:0]      tx_par_s;

  assign len_s = hdr_q[7:2];

  // Next-state, datapath updates, and output decode from the next state so every output is a flop.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    par_d        = par_q;
    wcnt_d       = wcnt_q;
    idx_d        = idx_q;
    ccnt_d       = ccnt_q;
    err_sticky_d = err_sticky_q;
    done_d       = 1'b0;
    status_err_d = 1'b0;
    buf_we_s     = 1'b0;
`ifdef ROUTER_TX_PAR_CORRUPT_EN
    corrupt_d    = corrupt_q;
`endif
    cmd_hs_s     = cmd_valid && cmd_ready_q;
    pl_hs_s      = pl_valid && pl_ready_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_hs_s) begin
          if ((cmd_len == 6'd0) || (cmd_addr == 2'd3)) begin
            done_d       = 1'b1;
            status_err_d = 1'b1;
          end else begin
            hdr_d   = {cmd_len, cmd_addr};
            par_d   = {cmd_len, cmd_addr};
            wcnt_d  = 6'd0;
            state_d = S_FILL;
`ifdef ROUTER_TX_PAR_CORRUPT_EN
            corrupt_d = corrupt;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (pl_hs_s) begin
          buf_we_s = 1'b1;
          par_d    = par_acc(par_q, pl_data);
          wcnt_d   = wcnt_q + 6'd1;
          if (wcnt_q == (len_s - 6'd1)) begin
            state_d = S_HDR;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_HDR: begin
        if (!busy) begin
          state_d = S_PLD;
          idx_d   = 6'd0;
        end else begin
          state_d = S_HDR;
        end
      end
      S_PLD: begin
        if (!busy) begin
          if (idx_q == (len_s - 6'd1)) begin
            state_d = S_PAR;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          state_d = S_PLD;
        end
      end
      S_PAR: begin
        if (!busy) begin
          state_d      = S_CHK;
          ccnt_d       = {CW{1'b0}};
          err_sticky_d = 1'b0;
        end else begin
          state_d = S_PAR;
        end
      end
      S_CHK: begin
        // The router flags parity errors a few cycles late, so err is accumulated over the whole window.
        err_sticky_d = err_sticky_q | err;
        ccnt_d       = ccnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (ccnt_q == CW'(ERR_WAIT - 1)) begin
          state_d      = S_IDLE;
          done_d       = 1'b1;
          status_err_d = err_sticky_q | err;
        end else begin
          state_d = S_CHK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef ROUTER_TX_PAR_CORRUPT_EN
    tx_par_s = corrupt_d ? ~par_d : par_d;
`else
    tx_par_s = par_d;
`endif

    case (state_d)
      S_HDR: begin
        data_out_d  = hdr_d;
        pkt_valid_d = 1'b1;
      end
      S_PLD: begin
        data_out_d  = pbuf_q[idx_d];
        pkt_valid_d = 1'b1;
      end
      S_PAR: begin
        data_out_d  = tx_par_s;
        pkt_valid_d = 1'b0;
      end
      default: begin
        data_out_d  = 8'h00;
        pkt_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    pl_ready_d  = (state_d == S_FILL);
    tx_active_d = (state_d == S_HDR) || (state_d == S_PLD) ||
                  (state_d == S_PAR) || (state_d == S_CHK);
  end

  // Control and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      hdr_q        <= 8'h00;
      par_q        <= 8'h00;
      wcnt_q       <= 6'd0;
      idx_q        <= 6'd0;
      ccnt_q       <= {CW{1'b0}};
      err_sticky_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
      pl_ready_q   <= 1'b0;
      data_out_q   <= 8'h00;
      pkt_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      status_err_q <= 1'b0;
      tx_active_q  <= 1'b0;
`ifdef ROUTER_TX_PAR_CORRUPT_EN
      corrupt_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      par_q        <= par_d;
      wcnt_q       <= wcnt_d;
      idx_q        <= idx_d;
      ccnt_q       <= ccnt_d;
      err_sticky_q <= err_sticky_d;
      cmd_ready_q  <= cmd_ready_d;
      pl_ready_q   <= pl_ready_d;
      data_out_q   <= data_out_d;
      pkt_valid_q  <= pkt_valid_d;
      done_q       <= done_d;
      status_err_q <= status_err_d;
      tx_active_q  <= tx_active_d;
`ifdef ROUTER_TX_PAR_CORRUPT_EN
      corrupt_q    <= corrupt_d;
`endif
    end
  end

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      pbuf_q[wcnt_q] <= pl_data;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign pl_ready   = pl_ready_q;
  assign data_out   = data_out_q;
  assign pkt_valid  = pkt_valid_q;
  assign done       = done_q;
  assign status_err = status_err_q;
  assign tx_active  = tx_active_q;

endmodule
